pointwise_vec_alu: RTL and testbench
====================================

POINTWISE_VEC_ALU -- requirements
Module: pointwise_vec_alu

Interface
REQ-001 Parameter DATA_W, default 16, element width in bits, two's-complement signed.
REQ-002 Parameter FRAC_W, default 8, fractional bits used by MUL mode.
REQ-003 Parameter N, default `MAX_NEURONS, elements per vector.
REQ-004 Parameter LANES, default 4, elements processed per cycle; N SHALL be a multiple of LANES.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  operand vectors and op are valid.
REQ-008 in_ready  out  1  block can accept a new vector pair.
REQ-009 op  in  2  00 SUB (a-b), 01 ADD (a+b), 10 MUL (fixed-point a*b), 11 RSUB (b-a).
REQ-010 vec_a  in  N*DATA_W  operand A; element i occupies bits [i*DATA_W +: DATA_W].
REQ-011 vec_b  in  N*DATA_W  operand B; same packing as vec_a.
REQ-012 out_valid  out  1  result vector is valid.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 vec_out  out  N*DATA_W  result vector; same packing as vec_a.
REQ-015 ovf  out  1  one or more elements overflowed in the current result.

Function
REQ-016 FSM states: IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 IDLE: on in_valid&in_ready, capture vec_a, vec_b and op into internal registers, clear chunk index and ovf, go to RUN.
REQ-018 RUN: each cycle compute LANES elements of chunk k (indices k*LANES .. k*LANES+LANES-1) from the captured operands and write them into vec_out; increment k.
REQ-019 RUN -> DONE on the edge that writes the last chunk (k == N/LANES-1); out_valid rises N/LANES+1 cycles after the accepting edge.
REQ-020 DONE: hold vec_out, ovf and out_valid stable until out_valid&out_ready, then go to IDLE; the next accept occurs no earlier than the following cycle.
REQ-021 Input changes after the accepting edge SHALL NOT affect the result.
REQ-022 ADD/SUB/RSUB: compute at DATA_W+1 bits; overflow when the result falls outside the signed DATA_W range.
REQ-023 MUL: 2*DATA_W-bit signed product, arithmetic shift right by FRAC_W (truncate toward -inf); overflow when the shifted value falls outside the signed DATA_W range.
REQ-024 Overflowing element: keep the low DATA_W bits (wrap) unless saturation is compiled in (REQ-030); ovf is OR of all element overflows and is sticky within one vector.
REQ-025 vec_out contents are don't-care while out_valid is low.

Reset
REQ-026 rst high at any clock edge: state=IDLE, chunk index=0, vec_out=0, ovf=0, out_valid=0; in_ready goes high on the cycle after rst deasserts.
REQ-027 rst during RUN or DONE discards the in-flight vector; no partial result is presented.
REQ-028 rst has priority over any simultaneous handshake.

Configuration
REQ-029 Macro POINTWISE_SATURATE_EN selects the overflow policy.
REQ-030 Macro defined: overflowing elements clamp to +(2^(DATA_W-1)-1) or -2^(DATA_W-1) according to sign; ovf still asserts. Macro undefined: wrap per REQ-024; no clamp logic is generated.

Structure
REQ-031 DATA_W default, FRAC_W default, the op encoding enum and the ARR-compatible packing stay in library_file.v; `MAX_NEURONS remains the N default source.
REQ-032 One sub-module pointwise_lane (one element: op, a, b -> result, ovf), instantiated LANES times by a generate loop; FSM, capture registers and the output register stay in the top module.

Verification (N=8, LANES=4, DATA_W=16, FRAC_W=8)
REQ-033 SUB, a[i]=3i, b[i]=i, accept at edge 0 -> out_valid at edge 3, out[i]=2i, ovf=0.
REQ-034 ADD, a[0]=0x7FFF, b[0]=0x0001, all other elements 0 -> out[0]=0x8000 with ovf=1 (macro off); out[0]=0x7FFF with ovf=1 (macro on).
REQ-035 MUL, a[i]=0x0180 (1.5), b[i]=0x0200 (2.0) -> out[i]=0x0300; a[1]=0xFF80 (-0.5) with b[1]=0x0100 -> out[1]=0xFF80.
REQ-036 out_ready held low 5 cycles in DONE -> out_valid, vec_out and ovf stable and in_ready low throughout; IDLE on the edge where out_ready rises.
REQ-037 rst pulsed 1 cycle during RUN (k=1) -> out_valid never rises for that vector; the next vector accepted after reset produces a correct result.
REQ-038 Two back-to-back vectors with out_ready tied high, op=RSUB -> each result is b-a, and each accept follows its predecessor's out handshake by exactly 1 cycle.

Source files
------------

// File: rtl/pointwise_vec_alu_pkg.sv
// Shared definitions for the pointwise vector ALU: op encoding, FSM states,
// default element widths and the default element count taken from `MAX_NEURONS.
`ifndef MAX_NEURONS
`define MAX_NEURONS 8
`endif

package pointwise_vec_alu_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_FRAC_W = 8;

    typedef enum logic [1:0] {
        OP_SUB  = 2'b00,
        OP_ADD  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSUB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

endpackage

// File: rtl/pointwise_lane.sv
// One element of the pointwise ALU: SUB/ADD/MUL/RSUB with overflow detection.
// Overflow policy: wrap by default, clamp when POINTWISE_SATURATE_EN is defined.
module pointwise_lane
    import pointwise_vec_alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  alu_op_e            op,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    output logic [DATA_W-1:0]  res,
    output logic               ovf
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] a_ext_s;
    logic signed [PW-1:0] b_ext_s;
    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] wide_s;

    assign a_ext_s = {{(PW-DATA_W){a[DATA_W-1]}}, a};
    assign b_ext_s = {{(PW-DATA_W){b[DATA_W-1]}}, b};
    assign prod_s  = a_ext_s * b_ext_s;

    // Full-precision result of the selected operation
    always_comb begin
        wide_s = '0;
        case (op)
            OP_SUB:  wide_s = a_ext_s - b_ext_s;
            OP_ADD:  wide_s = a_ext_s + b_ext_s;
            OP_MUL:  wide_s = prod_s >>> FRAC_W;
            OP_RSUB: wide_s = b_ext_s - a_ext_s;
            default: wide_s = '0;
        endcase
    end

    // Representable only if every bit above the result's sign bit repeats it
    assign ovf = (wide_s[PW-1:DATA_W-1] != {(PW-DATA_W+1){wide_s[DATA_W-1]}});

`ifdef POINTWISE_SATURATE_EN
    assign res = ovf ? (wide_s[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}})
                     : wide_s[DATA_W-1:0];
`else
    assign res = wide_s[DATA_W-1:0];
`endif

endmodule

// File: rtl/pointwise_vec_alu.sv
// Pointwise vector ALU: accepts a vector pair, streams it LANES elements per
// cycle through pointwise_lane, presents the full result (POINTWISE_SATURATE_EN
// selects clamp instead of wrap on overflow).
module pointwise_vec_alu
    import pointwise_vec_alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int N      = `MAX_NEURONS,
    parameter int LANES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          op,
    input  logic [N*DATA_W-1:0] vec_a,
    input  logic [N*DATA_W-1:0] vec_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*DATA_W-1:0] vec_out,
    output logic                ovf
);

    localparam int NCHUNK = N / LANES;
    localparam int CW     = LANES * DATA_W;
    localparam int VW     = N * DATA_W;
    localparam int KW     = $clog2(NCHUNK + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK);

    alu_state_e       state_r;
    alu_state_e       state_nx_s;
    logic [KW-1:0]    k_r;
    logic [VW-1:0]    a_r;
    logic [VW-1:0]    b_r;
    alu_op_e          op_r;
    logic [VW-1:0]    out_r;
    logic [VW-1:0]    out_next_s;
    logic             ovf_r;
    logic [CW-1:0]    lane_res_s;
    logic [CW-1:0]    lane_res_r;
    logic [LANES-1:0] lane_ovf_s;
    logic             lane_ovf_r;
    logic             accept_s;

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign vec_out   = out_r;
    assign ovf       = ovf_r;
    assign accept_s  = (state_r == ST_IDLE) && in_valid;

    // Operand registers shift down one chunk per RUN cycle, so lanes always read the low chunk
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            pointwise_lane #(
                .DATA_W (DATA_W),
                .FRAC_W (FRAC_W)
            ) u_lane (
                .op  (op_r),
                .a   (a_r[l*DATA_W +: DATA_W]),
                .b   (b_r[l*DATA_W +: DATA_W]),
                .res (lane_res_s[l*DATA_W +: DATA_W]),
                .ovf (lane_ovf_s[l])
            );
        end

        // Finished chunks enter at the top; after NCHUNK writes chunk 0 sits at the bottom
        if (NCHUNK > 1) begin : g_shift
            assign out_next_s = {lane_res_r, out_r[VW-1:CW]};
        end else begin : g_noshift
            assign out_next_s = lane_res_r;
        end
    endgenerate

    // Next-state decode for the IDLE/RUN/DONE handshake sequence
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_nx_s = ST_RUN;
                else          state_nx_s = ST_IDLE;
            end
            ST_RUN: begin
                if (k_r == K_LAST) state_nx_s = ST_DONE;
                else               state_nx_s = ST_RUN;
            end
            ST_DONE: begin
                if (out_ready) state_nx_s = ST_IDLE;
                else           state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nx_s;
    end

    // Operand capture on accept and chunk shifting during RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            op_r <= OP_SUB;
        end else if (accept_s) begin
            a_r  <= vec_a;
            b_r  <= vec_b;
            op_r <= alu_op_e'(op);
        end else if (state_r == ST_RUN) begin
            a_r  <= a_r >> CW;
            b_r  <= b_r >> CW;
        end
    end

    // Chunk index and one-cycle lane result register
    always_ff @(posedge clk) begin
        if (rst) begin
            k_r        <= '0;
            lane_res_r <= '0;
            lane_ovf_r <= 1'b0;
        end else if (accept_s) begin
            k_r        <= '0;
        end else if (state_r == ST_RUN) begin
            k_r        <= k_r + KW'(1);
            lane_res_r <= lane_res_s;
            lane_ovf_r <= |lane_ovf_s;
        end
    end

    // Result assembly and sticky per-vector overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r <= '0;
            ovf_r <= 1'b0;
        end else if (accept_s) begin
            ovf_r <= 1'b0;
        end else if ((state_r == ST_RUN) && (k_r != {KW{1'b0}})) begin
            out_r <= out_next_s;
            ovf_r <= ovf_r | lane_ovf_r;
        end
    end

endmodule

// File: tb/tb_pointwise_vec_alu.sv
// Bench for pointwise_vec_alu: directed vector table, handshake/reset corner
// sequences and randomized vectors checked against an integer reference model.
`timescale 1ns/1ps
module tb_pointwise_vec_alu;

    localparam int DW   = 16;
    localparam int NE   = 8;
    localparam int FRAC = 8;
    localparam int VW   = NE * DW;
    localparam int CKW  = VW + 8;

    typedef struct {
        string         name;
        logic [1:0]    op;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [VW-1:0] exp_out;
        logic          exp_ovf;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [VW-1:0] vec_a;
    logic [VW-1:0] vec_b;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] vec_out;
    logic          ovf;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int accept_cyc = 0;
    vec_t tbl[6];

    pointwise_vec_alu #(
        .DATA_W (DW),
        .FRAC_W (FRAC),
        .N      (NE),
        .LANES  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vec_out   (vec_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [CKW-1:0] act, input logic [CKW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < NE; i++) begin
            if (($urandom & 32'd3) == 32'd0) v[i*DW +: DW] = DW'($urandom_range(0, 511) - 256);
            else                             v[i*DW +: DW] = DW'($urandom);
        end
        return v;
    endfunction

    // Reference: integer arithmetic per element, floor division for MUL
    task automatic ref_vec(input logic [1:0] o, input logic [VW-1:0] a, input logic [VW-1:0] b,
                           output logic [VW-1:0] r, output logic ov);
        longint sa, sb, x, p;
        r  = '0;
        ov = 1'b0;
        for (int i = 0; i < NE; i++) begin
            sa = longint'($signed(a[i*DW +: DW]));
            sb = longint'($signed(b[i*DW +: DW]));
            case (o)
                2'b00:   x = sa - sb;
                2'b01:   x = sa + sb;
                2'b11:   x = sb - sa;
                default: begin
                    p = sa * sb;
                    x = p / (64'sd1 << FRAC);
                    if (p < 0 && (p % (64'sd1 << FRAC)) != 0) x = x - 1;
                end
            endcase
            if (x > 32767 || x < -32768) begin
                ov = 1'b1;
`ifdef POINTWISE_SATURATE_EN
                x = (x > 0) ? 64'sd32767 : -64'sd32768;
`endif
            end
            r[i*DW +: DW] = x[DW-1:0];
        end
    endtask

    task automatic send(input logic [1:0] o, input logic [VW-1:0] a, input logic [VW-1:0] b);
        bit ok;
        ok = 1'b0;
        op = o; vec_a = a; vec_b = b; in_valid = 1'b1;
        for (int g = 0; g < 50 && !ok; g++) begin
            if (in_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            n_total++;
            $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
            in_valid = 1'b0;
        end else begin
            accept_cyc = cyc + 1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            op = 2'($urandom);
            vec_a = rand_vec();
            vec_b = rand_vec();
        end
    endtask

    task automatic wait_out(output int lat);
        bit ok;
        ok = 1'b0;
        for (int g = 0; g < 50 && !ok; g++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        lat = cyc - accept_cyc;
        if (!ok) begin
            n_total++;
            $display("FAIL out_timeout: out_valid stayed %b, expected 1", out_valid);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, acc2, hs1;
        bit seen;
        logic [VW-1:0] r1, r2, m1, m2, snap;
        logic mo1, mo2, snap_ovf;
        logic [1:0] rop;

        // Directed vectors with hand-derived expectations
        foreach (tbl[e]) begin
            tbl[e].a = '0; tbl[e].b = '0; tbl[e].exp_out = '0; tbl[e].exp_ovf = 1'b0;
        end
        tbl[0].name = "sub_ramp"; tbl[0].op = 2'b00;
        for (int i = 0; i < NE; i++) begin
            tbl[0].a[i*DW +: DW] = DW'(3 * i);
            tbl[0].b[i*DW +: DW] = DW'(i);
            tbl[0].exp_out[i*DW +: DW] = DW'(2 * i);
        end
        tbl[1].name = "add_ovf"; tbl[1].op = 2'b01; tbl[1].exp_ovf = 1'b1;
        tbl[1].a[0 +: DW] = 16'h7FFF; tbl[1].b[0 +: DW] = 16'h0001;
`ifdef POINTWISE_SATURATE_EN
        tbl[1].exp_out[0 +: DW] = 16'h7FFF;
`else
        tbl[1].exp_out[0 +: DW] = 16'h8000;
`endif
        tbl[2].name = "mul_fix"; tbl[2].op = 2'b10;
        for (int i = 0; i < NE; i++) begin
            tbl[2].a[i*DW +: DW] = 16'h0180;
            tbl[2].b[i*DW +: DW] = 16'h0200;
            tbl[2].exp_out[i*DW +: DW] = 16'h0300;
        end
        tbl[2].a[DW +: DW] = 16'hFF80; tbl[2].b[DW +: DW] = 16'h0100; tbl[2].exp_out[DW +: DW] = 16'hFF80;
        tbl[3].name = "rsub_ramp"; tbl[3].op = 2'b11;
        for (int i = 0; i < NE; i++) begin
            tbl[3].a[i*DW +: DW] = DW'(i + 1);
            tbl[3].b[i*DW +: DW] = DW'(10 * i);
            tbl[3].exp_out[i*DW +: DW] = DW'(9 * i - 1);
        end
        tbl[4].name = "sub_negovf"; tbl[4].op = 2'b00; tbl[4].exp_ovf = 1'b1;
        for (int i = 0; i < NE; i++) begin
            tbl[4].a[i*DW +: DW] = 16'hFFFB;
            tbl[4].b[i*DW +: DW] = 16'h0007;
            tbl[4].exp_out[i*DW +: DW] = 16'hFFF4;
        end
        tbl[4].a[3*DW +: DW] = 16'h8000; tbl[4].b[3*DW +: DW] = 16'h0001;
`ifdef POINTWISE_SATURATE_EN
        tbl[4].exp_out[3*DW +: DW] = 16'h8000;
`else
        tbl[4].exp_out[3*DW +: DW] = 16'h7FFF;
`endif
        tbl[5].name = "mul_floor_ovf"; tbl[5].op = 2'b10; tbl[5].exp_ovf = 1'b1;
        tbl[5].a[0 +: DW] = 16'hFFFF; tbl[5].b[0 +: DW] = 16'h0080; tbl[5].exp_out[0 +: DW] = 16'hFFFF;
        tbl[5].a[DW +: DW] = 16'h7FFF; tbl[5].b[DW +: DW] = 16'h7FFF;
`ifdef POINTWISE_SATURATE_EN
        tbl[5].exp_out[DW +: DW] = 16'h7FFF;
`else
        tbl[5].exp_out[DW +: DW] = 16'hFF00;
`endif
        tbl[5].a[2*DW +: DW] = 16'h0100; tbl[5].b[2*DW +: DW] = 16'h0100; tbl[5].exp_out[2*DW +: DW] = 16'h0100;

        // Reset values
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; vec_a = '0; vec_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", CKW'(out_valid), CKW'(1'b0));
        chk("rst_vec_out", CKW'(vec_out), CKW'(0));
        chk("rst_ovf", CKW'(ovf), CKW'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", CKW'(in_ready), CKW'(1'b1));

        // Table-driven vectors, consumer always ready
        out_ready = 1'b1;
        for (int e = 0; e < 6; e++) begin
            send(tbl[e].op, tbl[e].a, tbl[e].b);
            wait_out(lat);
            chk({tbl[e].name, "_latency"}, CKW'(lat), CKW'(3));
            chk({tbl[e].name, "_out"}, CKW'(vec_out), CKW'(tbl[e].exp_out));
            chk({tbl[e].name, "_ovf"}, CKW'(ovf), CKW'(tbl[e].exp_ovf));
        end

        // Consumer stalls five cycles in DONE
        @(negedge clk);
        out_ready = 1'b0;
        send(tbl[2].op, tbl[2].a, tbl[2].b);
        wait_out(lat);
        snap = vec_out; snap_ovf = ovf;
        chk("hold_out", CKW'(vec_out), CKW'(tbl[2].exp_out));
        for (int h = 0; h < 5; h++) begin
            if (h > 0) @(negedge clk);
            chk("hold_stable", CKW'({out_valid, ovf, in_ready, vec_out}), CKW'({1'b1, snap_ovf, 1'b0, snap}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release", CKW'({in_ready, out_valid}), CKW'(2'b10));

        // Reset pulse mid-RUN discards the vector
        send(tbl[0].op, tbl[0].a, tbl[0].b);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_vec_out", CKW'(vec_out), CKW'(0));
        seen = 1'b0;
        for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_out", CKW'(seen), CKW'(1'b0));
        chk("midrst_in_ready", CKW'(in_ready), CKW'(1'b1));
        send(tbl[3].op, tbl[3].a, tbl[3].b);
        wait_out(lat);
        chk("after_rst_out", CKW'(vec_out), CKW'(tbl[3].exp_out));

        // Back-to-back RSUB vectors with out_ready tied high
        @(negedge clk);
        r1 = rand_vec(); m1 = rand_vec();
        r2 = rand_vec(); m2 = rand_vec();
        send(2'b11, r1, m1);
        ref_vec(2'b11, r1, m1, snap, mo1);
        op = 2'b11; vec_a = r2; vec_b = m2; in_valid = 1'b1;
        acc2 = -1; hs1 = -1; r1 = '0;
        for (int g = 0; g < 50 && acc2 < 0; g++) begin
            @(negedge clk);
            if (out_valid && out_ready && hs1 < 0) begin
                hs1 = cyc + 1;
                r1 = vec_out;
            end
            if (in_ready) acc2 = cyc + 1;
        end
        if (acc2 < 0) begin
            n_total++;
            $display("FAIL b2b_accept_timeout: in_ready stayed %b, expected 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            accept_cyc = acc2;
            chk("b2b_first", CKW'(r1), CKW'(snap));
            chk("b2b_accept_gap", CKW'(acc2 - hs1), CKW'(1));
            wait_out(lat);
            ref_vec(2'b11, r2, m2, m1, mo2);
            chk("b2b_second", CKW'(vec_out), CKW'(m1));
            chk("b2b_second_ovf", CKW'(ovf), CKW'(mo2));
        end

        // Randomized vectors with random consumer stalls
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            out_ready = 1'b0;
            rop = 2'($urandom);
            r1 = rand_vec(); r2 = rand_vec();
            send(rop, r1, r2);
            ref_vec(rop, r1, r2, m1, mo1);
            wait_out(lat);
            chk("rand_out", CKW'(vec_out), CKW'(m1));
            chk("rand_ovf", CKW'(ovf), CKW'(mo1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
